// File: rtl/wb_regfile.sv
// Write-back stage register file: selects load/ALU data, clears all entries after reset, then commits writes.
// Optional macro WB_BYPASS_EN: same-cycle write-through from wb_data to the read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inreadData,
  input  logic [DATA_W-1:0] inAluResult,
  input  logic [ADDR_W-1:0] inmuxRegFileD,
  input  logic              inregWrite,
  input  logic              inmemtoReg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              ready,
  output logic [CNT_W-1:0]  retire_count,
  output logic              dbg_state
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam int NREGS = 2 ** ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   regs [NREGS];
  logic                clr_last;
  logic                wr_en;

  assign wb_data   = inmemtoReg ? inreadData : inAluResult;
  assign ready     = (state_q == RUN);
  assign dbg_state = state_q;

  // Index 0 is never a real destination, so it is neither written nor counted.
  assign wr_en    = (state_q == RUN) && inregWrite && (inmuxRegFileD != '0);
  assign clr_last = (clr_idx == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (clr_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_idx      <= ADDR_W'(1);
      retire_count <= '0;
    end else if (state_q == INIT) begin
      regs[clr_idx] <= '0;
      clr_idx       <= clr_idx + ADDR_W'(1);
    end else if (wr_en) begin
      regs[inmuxRegFileD] <= wb_data;
      retire_count        <= retire_count + CNT_W'(1);
    end
  end

  // Entry 0 storage is never written; the read mux forces it to zero.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (ready && rs_addr != '0) begin
`ifdef WB_BYPASS_EN
      if (wr_en && rs_addr == inmuxRegFileD) rs_data = wb_data;
      else                                   rs_data = regs[rs_addr];
`else
      rs_data = regs[rs_addr];
`endif
    end
    if (ready && rt_addr != '0) begin
`ifdef WB_BYPASS_EN
      if (wr_en && rt_addr == inmuxRegFileD) rt_data = wb_data;
      else                                   rt_data = regs[rt_addr];
`else
      rt_data = regs[rt_addr];
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: array-based reference model checked every negedge, plus directed literal checks.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] inreadData;
  logic [31:0] inAluResult;
  logic [4:0]  inmuxRegFileD;
  logic        inregWrite;
  logic        inmemtoReg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        ready;
  logic [15:0] retire_count;
  logic        dbg_state;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .inreadData(inreadData), .inAluResult(inAluResult),
    .inmuxRegFileD(inmuxRegFileD), .inregWrite(inregWrite), .inmemtoReg(inmemtoReg),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
    .ready(ready), .retire_count(retire_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: all entries read as zero until 31 edges after reset release
  logic [31:0] m_regs [32];
  int          m_since = 0;
  logic [15:0] m_cnt   = '0;
  bit          m_valid = 0;

  function automatic logic [31:0] m_wb();
    return inmemtoReg ? inreadData : inAluResult;
  endfunction

  function automatic bit m_ready();
    return m_since >= 31;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!m_ready() || a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (inregWrite && inmuxRegFileD == a) return m_wb();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1;
      m_since = 0;
      m_cnt   = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (m_valid) begin
      if (m_since < 31) m_since++;
      else if (inregWrite && inmuxRegFileD != 5'd0) begin
        m_regs[inmuxRegFileD] = m_wb();
        m_cnt++;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    check("wb_data", wb_data, m_wb());
    if (m_valid) begin
      check("ready", {31'h0, ready}, {31'h0, m_ready()});
      check("dbg_state", {31'h0, dbg_state}, {31'h0, m_ready()});
      check("retire_count", {16'h0, retire_count}, {16'h0, m_cnt});
      check("rs_data", rs_data, m_read(rs_addr));
      check("rt_data", rt_data, m_read(rt_addr));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wr(input logic we, input logic mtr, input logic [4:0] dest,
                        input logic [31:0] rd, input logic [31:0] alu);
    inregWrite    = we;
    inmemtoReg    = mtr;
    inmuxRegFileD = dest;
    inreadData    = rd;
    inAluResult   = alu;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
    check(name, n, 31);
  endtask

  initial begin
    rst_n = 1'b0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    repeat (3) step();
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_count", {16'h0, retire_count}, 32'h0);

    // 1: clear sequence length, all entries zero
    rst_n = 1'b1;
    wait_ready("init_edges");
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check("clear_rs", rs_data, 32'h0);
      step();
    end

    // 2: ALU write to r5
    set_wr(1'b1, 1'b0, 5'd5, 32'h0BAD_0BAD, 32'h1234_5678);
    step();
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs_addr = 5'd5;
    #1;
    check("t2_rs", rs_data, 32'h1234_5678);
    check("t2_count", {16'h0, retire_count}, 32'd1);

    // 3: load write to r31
    set_wr(1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h5555_AAAA);
    #1;
    check("t3_wb", wb_data, 32'hDEAD_BEEF);
    step();
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rt_addr = 5'd31;
    #1;
    check("t3_rt", rt_data, 32'hDEAD_BEEF);

    // 4: write to r0 is ignored
    set_wr(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    step();
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs_addr = 5'd0;
    #1;
    check("t4_r0", rs_data, 32'h0);
    check("t4_count", {16'h0, retire_count}, 32'd2);

    // 5: read/write collision on r7
    set_wr(1'b1, 1'b0, 5'd7, 32'h0, 32'h1);
    step();
    rs_addr = 5'd7;
    rt_addr = 5'd7;
    set_wr(1'b1, 1'b0, 5'd7, 32'h0, 32'h2);
    #1;
`ifdef WB_BYPASS_EN
    check("t5_rs_same", rs_data, 32'h2);
    check("t5_rt_same", rt_data, 32'h2);
`else
    check("t5_rs_same", rs_data, 32'h1);
    check("t5_rt_same", rt_data, 32'h1);
`endif
    step();
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check("t5_rs_after", rs_data, 32'h2);
    check("t5_count", {16'h0, retire_count}, 32'd4);

    // a few mixed writes
    for (int i = 1; i <= 6; i++) begin
      set_wr(1'b1, i[0], 5'(i * 4), 32'hC000_0000 + i, 32'hA000_0000 + i);
      rs_addr = 5'(i * 4 - 4);
      step();
    end
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs_addr = 5'd8;
    rt_addr = 5'd12;
    #1;
    check("mix_r8", rs_data, 32'hA000_0002);
    check("mix_r12", rt_data, 32'hC000_0003);

    // 6: reset in the middle of INIT with pipe writes active
    set_wr(1'b1, 1'b0, 5'd3, 32'h0, 32'hA5);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_wr(1'b1, 1'b0, 5'd3, 32'h0, 32'h77);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    check("t6_ready_low", {31'h0, ready}, 32'h0);
    rst_n = 1'b1;
    wait_ready("t6_init_edges");
    set_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs_addr = 5'd3;
    #1;
    check("t6_r3", rs_data, 32'h0);
    check("t6_count", {16'h0, retire_count}, 32'h0);
    step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
